kbd_ctrl: RTL and testbench

KBD_CTRL -- requirements
Module: kbd_ctrl

---
 rtl/kbd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_kbd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: keyboard scancode FIFO with a single-cycle-ack bus slave.
// Register map (s_addr[3:2]):
//   0 DATA   : read pops the head byte (0 when empty), writes ignored
//   1 STATUS : {count[12:8], overflow[2], full[1], !empty[0]}; write bit2=1 clears overflow
//   2 CTRL   : bit0 irq_en (r/w), bit1 flush (write-1, reads 0)
//   3 reserved
module kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        key_ready,
  input  logic        s_cyc,
  input  logic        s_we,
  input  logic [3:0]  s_strb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data_i,
  output logic        s_ack,
  output logic [31:0] s_data_o,
  output logic        kbd_irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  typedef enum logic [0:0] {StIdle, StAck} bus_state_e;

  bus_state_e     state;

  // Access captured on the IDLE->ACK edge; acted on at the edge ending ACK.
  logic           req_we;
  logic           req_strb0;
  logic [1:0]     req_addr;
  logic [2:0]     req_data;
  logic           pop_pend;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           irq_en;

  logic           full;
  logic           empty;
  logic           push;
  logic           in_ack;
  logic           do_pop;
  logic           do_wr;
  logic           do_flush;
  logic           ovf_set;
  logic           ovf_clr;
  logic [4:0]     count5;
  logic [31:0]    rdata;

  // Only a few address/strobe/data bits carry meaning.
  logic           unused_bits;
  assign unused_bits = ^{s_strb[3:1], s_addr[31:4], s_addr[1:0], s_data_i[31:3]};

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign key_ready = ~full;
  assign push      = key_valid & ~full;
  assign ovf_set   = key_valid & full;

  assign in_ack    = (state == StAck);
  assign do_pop    = in_ack & pop_pend;
  assign do_wr     = in_ack & req_we & req_strb0;
  assign do_flush  = do_wr & (req_addr == RegCtrl) & req_data[1];
  assign ovf_clr   = do_wr & (req_addr == RegStatus) & req_data[2];

  assign count5    = 5'(count);

  // Read data for the access being started this cycle.
  always_comb begin
    rdata = '0;
    if (!s_we) begin
      case (s_addr[3:2])
        RegData: begin
          if (!empty) rdata[7:0] = mem[rd_ptr];
        end
        RegStatus: begin
          rdata[12:8] = count5;
          rdata[2:0]  = {overflow, full, ~empty};
        end
        RegCtrl: begin
          rdata[0] = irq_en;
        end
        default: ;
      endcase
    end
  end

  // Bus FSM with registered ack/read data; request fields latched at access start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      s_ack     <= 1'b0;
      s_data_o  <= '0;
      req_we    <= 1'b0;
      req_strb0 <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      pop_pend  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (s_cyc) begin
            state     <= StAck;
            s_ack     <= 1'b1;
            s_data_o  <= rdata;
            req_we    <= s_we;
            req_strb0 <= s_strb[0];
            req_addr  <= s_addr[3:2];
            req_data  <= s_data_i[2:0];
            // Pop decision is fixed here so a read that saw empty never pops
            // an entry pushed while the access is in flight.
            pop_pend  <= ~s_we & (s_addr[3:2] == RegData) & ~empty;
          end
        end
        StAck: begin
          state    <= StIdle;
          s_ack    <= 1'b0;
          s_data_o <= '0;
          pop_pend <= 1'b0;
        end
        default: begin
          state    <= StIdle;
          s_ack    <= 1'b0;
          s_data_o <= '0;
          pop_pend <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; flush beats any same-edge push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scancode storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  // Sticky overflow (set wins over clear), irq enable and registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      kbd_irq  <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (do_wr && (req_addr == RegCtrl)) irq_en <= req_data[0];
      kbd_irq  <= irq_en & (~empty | overflow);
    end
  end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Bench for kbd_ctrl: queue-based model checked every cycle plus literal spot checks.
module tb_kbd_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ready;
  logic        s_cyc;
  logic        s_we;
  logic [3:0]  s_strb;
  logic [31:0] s_addr;
  logic [31:0] s_data_i;
  logic        s_ack;
  logic [31:0] s_data_o;
  logic        kbd_irq;

  kbd_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .s_cyc     (s_cyc),
    .s_we      (s_we),
    .s_strb    (s_strb),
    .s_addr    (s_addr),
    .s_data_i  (s_data_i),
    .s_ack     (s_ack),
    .s_data_o  (s_data_o),
    .kbd_irq   (kbd_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  byte unsigned q[$];
  bit           m_ovf, m_irq_en, m_irq;
  bit           m_busy;           // an access is in its ack cycle
  bit           m_we, m_pop;
  bit [3:0]     m_strb;
  bit [1:0]     m_reg;
  bit [31:0]    m_wdata, m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic [31:0] w;
    int n;
    n = q.size();
    w = '0;
    w[12:8] = 5'(n);
    w[2] = m_ovf;
    w[1] = (n == DEPTH);
    w[0] = (n != 0);
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_irq_en = 0; m_irq = 0; m_busy = 0;
    m_we = 0; m_pop = 0; m_strb = 0; m_reg = 0; m_wdata = 0; m_rdata = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int n;
    bit full, irq_nx, clr, flush, start, pop_now;
    logic [31:0] rd;
    n = q.size();
    full = (n == DEPTH);
    irq_nx = m_irq_en && (n != 0 || m_ovf);
    clr = 0; flush = 0; pop_now = 0; rd = '0;
    start = !m_busy && s_cyc;
    if (start && !s_we) begin
      case (s_addr[3:2])
        2'd0: if (n != 0) begin rd = {24'b0, q[0]}; pop_now = 1; end
        2'd1: rd = status_word();
        2'd2: rd = {31'b0, m_irq_en};
        default: rd = '0;
      endcase
    end
    if (m_busy) begin
      if (m_pop) void'(q.pop_front());
      if (m_we && m_strb[0]) begin
        if (m_reg == 2'd1 && m_wdata[2]) clr = 1;
        if (m_reg == 2'd2) begin
          m_irq_en = m_wdata[0];
          flush = m_wdata[1];
        end
      end
    end
    if (key_valid && !full) q.push_back(key_code);
    if (flush) q.delete();
    m_ovf = (m_ovf && !clr) || (key_valid && full);
    m_irq = irq_nx;
    if (start) begin
      m_busy = 1; m_we = s_we; m_strb = s_strb; m_reg = s_addr[3:2];
      m_wdata = s_data_i; m_pop = pop_now; m_rdata = rd;
    end else begin
      m_busy = 0; m_pop = 0; m_rdata = '0;
    end
  endtask

  task automatic compare();
    check("s_ack", {31'b0, s_ack}, {31'b0, m_busy});
    check("s_data_o", s_data_o, m_rdata);
    check("key_ready", {31'b0, key_ready}, {31'b0, q.size() != DEPTH});
    check("kbd_irq", {31'b0, kbd_irq}, {31'b0, m_irq});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [7:0] code);
    key_valid = 1; key_code = code;
    cycle();
    key_valid = 0; key_code = '0;
  endtask

  task automatic bus_start(input bit we, input bit [3:0] strb, input bit [1:0] r,
                           input bit [31:0] d);
    s_cyc = 1; s_we = we; s_strb = strb; s_data_i = d;
    s_addr = {28'h5A5A5A5, r, 2'b11};  // undecoded bits deliberately non-zero
    cycle();
    s_cyc = 0; s_we = 0; s_strb = '0; s_addr = '0; s_data_i = '0;
  endtask

  task automatic bus_rd(input bit [1:0] r, output logic [31:0] v);
    bus_start(1'b0, 4'h0, r, 32'h0);
    v = s_data_o;
    cycle();
  endtask

  task automatic bus_wr(input bit [1:0] r, input bit [3:0] strb, input bit [31:0] d);
    bus_start(1'b1, strb, r, d);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst = 1; key_valid = 0; key_code = '0;
    s_cyc = 0; s_we = 0; s_strb = '0; s_addr = '0; s_data_i = '0;
    #1;
    check("rst_key_ready", {31'b0, key_ready}, 32'd1);
    check("rst_s_ack", {31'b0, s_ack}, 32'd0);
    check("rst_s_data_o", s_data_o, 32'd0);
    check("rst_kbd_irq", {31'b0, kbd_irq}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Two codes come out in order, then an empty read returns 0.
    push(8'h1C);
    push(8'h32);
    bus_rd(2'd0, v); check("rd_first", v, 32'h1C);
    bus_rd(2'd0, v); check("rd_second", v, 32'h32);
    bus_rd(2'd0, v); check("rd_empty", v, 32'h0);
    bus_rd(2'd1, v); check("status_empty", v, 32'h0);

    // Fill past depth: ninth code overflows.
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h10 + i));
      if (i == 7) check("ready_after_8", {31'b0, key_ready}, 32'd0);
    end
    bus_rd(2'd1, v); check("status_full_ovf", v, 32'h0000_0807);
    bus_wr(2'd1, 4'h1, 32'h4);
    bus_rd(2'd1, v); check("status_ovf_clr", v, 32'h0000_0803);

    // Full FIFO: push dropped while a pop completes on the same edge.
    bus_start(1'b0, 4'h0, 2'd0, 32'h0);
    check("rd_full_head", s_data_o, 32'h10);
    key_valid = 1; key_code = 8'hEE;
    cycle();
    key_valid = 0; key_code = '0;
    bus_rd(2'd1, v); check("status_drop", v, 32'h0000_0705);
    bus_rd(2'd0, v); check("head_advanced", v, 32'h11);

    // Ignored writes: DATA, reserved, STATUS without strobe.
    bus_wr(2'd0, 4'hF, 32'hFF);
    bus_wr(2'd3, 4'hF, 32'hFFFF_FFFF);
    bus_wr(2'd1, 4'hE, 32'h4);
    bus_rd(2'd3, v); check("reserved_rd", v, 32'h0);
    bus_rd(2'd1, v); check("status_ignored_wr", v, 32'h0000_0605);

    // Interrupt: enable, push, then drain.
    bus_wr(2'd2, 4'h1, 32'h2);
    bus_wr(2'd1, 4'h1, 32'h4);
    bus_rd(2'd1, v); check("status_after_flush", v, 32'h0);
    bus_wr(2'd2, 4'h1, 32'h1);
    bus_rd(2'd2, v); check("ctrl_rd", v, 32'h1);
    push(8'h5A);
    idle(1);
    check("irq_set", {31'b0, kbd_irq}, 32'd1);
    bus_rd(2'd0, v); check("irq_rd", v, 32'h5A);
    idle(1);
    check("irq_clear", {31'b0, kbd_irq}, 32'd0);

    // Flush with enable and a same-edge push.
    bus_wr(2'd2, 4'h1, 32'h0);
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    bus_rd(2'd1, v); check("status_five", v, 32'h0000_0501);
    bus_start(1'b1, 4'h1, 2'd2, 32'h3);
    key_valid = 1; key_code = 8'h77;
    cycle();
    key_valid = 0; key_code = '0;
    check("flush_irq", {31'b0, kbd_irq}, 32'd0);
    idle(1);
    check("flush_irq_later", {31'b0, kbd_irq}, 32'd0);
    bus_rd(2'd2, v); check("flush_ctrl", v, 32'h1);
    bus_rd(2'd1, v); check("flush_status", v, 32'h0);

    // Pointer wrap and overflow under mixed traffic.
    for (int i = 0; i < 20; i++) begin
      push(8'(i));
      push(8'(i + 100));
      bus_rd(2'd0, v);
    end
    bus_wr(2'd2, 4'h1, 32'h3);
    bus_wr(2'd1, 4'h1, 32'h4);

    // Empty-FIFO read with a push on the completing edge: returns 0, push lands.
    bus_start(1'b0, 4'h0, 2'd0, 32'h0);
    check("empty_pop_data", s_data_o, 32'h0);
    key_valid = 1; key_code = 8'h99;
    cycle();
    key_valid = 0; key_code = '0;
    bus_rd(2'd1, v); check("empty_pop_status", v, 32'h0000_0101);
    bus_rd(2'd0, v); check("empty_pop_code", v, 32'h99);

    // Reset in the middle of a DATA read ack.
    for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
    bus_start(1'b0, 4'h0, 2'd0, 32'h0);
    check("pre_rst_data", s_data_o, 32'hA0);
    #2;
    rst = 1;
    #1;
    check("mid_rst_s_ack", {31'b0, s_ack}, 32'd0);
    check("mid_rst_s_data_o", s_data_o, 32'h0);
    check("mid_rst_key_ready", {31'b0, key_ready}, 32'd1);
    check("mid_rst_kbd_irq", {31'b0, kbd_irq}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus_rd(2'd1, v); check("post_rst_status", v, 32'h0);
    bus_rd(2'd2, v); check("post_rst_ctrl", v, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
